// File: rtl/ifu_fetch_unit_pkg.sv
// ifu_fetch_unit_pkg: instruction codes, next-PC selector encodings and opcode/funct constants
package ifu_fetch_unit_pkg;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  typedef enum logic [5:0] {
    INST_NOP, INST_ADDU, INST_SUBU, INST_SLT, INST_JR, INST_SRAV,
    INST_ORI, INST_LW, INST_SW, INST_BEQ, INST_LUI, INST_J, INST_ADDI,
    INST_ADDIU, INST_JAL, INST_SB, INST_LB, INST_HLT, INST_BAD
  } inst_e;
  typedef enum logic [1:0] {
    IFU_SEL_NORM, IFU_SEL_RELATIVE, IFU_SEL_IRRELATIVE, IFU_SEL_REGISTER
  } npc_sel_e;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_LUI = 6'h0F, OP_J = 6'h02, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_JAL = 6'h03, OP_SB = 6'h28, OP_LB = 6'h20, OP_HLT = 6'h3F;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_SLT = 6'h2A, FN_JR = 6'h08, FN_SRAV = 6'h07;
endpackage

// File: rtl/ifu_fetch_unit_if.sv
// ifu_fetch_unit_if: controller and instruction-memory bus of the fetch unit
interface ifu_fetch_unit_if #(parameter int IM_ADDR_W = 10);
  logic pc_write_en, im_next_en, halt_sig;
  logic [1:0] npc_sel;
  logic [31:0] rs_data, imem_rdata, pc, instr, fetch_count;
  logic [IM_ADDR_W-1:0] imem_addr;
  logic [5:0] dec_inst;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm16;
  logic halted, pc_fault;
  modport master(
    output pc_write_en, im_next_en, halt_sig, npc_sel, rs_data, imem_rdata,
    input pc, instr, fetch_count, imem_addr, dec_inst, rs, rt, rd, imm16, halted, pc_fault
  );
  modport slave(
    input pc_write_en, im_next_en, halt_sig, npc_sel, rs_data, imem_rdata,
    output pc, instr, fetch_count, imem_addr, dec_inst, rs, rt, rd, imm16, halted, pc_fault
  );
endinterface

// File: rtl/ifu_fetch_unit_inst_decode.sv
// ifu_fetch_unit_inst_decode: maps an instruction word to its INST_* code
module ifu_fetch_unit_inst_decode
  import ifu_fetch_unit_pkg::*;
(
  input logic [31:0] ir,
  output logic [5:0] dec
);
  // all-zero word is a NOP; op 0 dispatches on funct; everything unlisted is BAD
  always_comb begin
    dec = INST_BAD;
    if (ir == 32'd0) dec = INST_NOP;
    else
      case (ir[31:26])
        OP_SPECIAL:
          case (ir[5:0])
            FN_ADDU: dec = INST_ADDU;
            FN_SUBU: dec = INST_SUBU;
            FN_SLT:  dec = INST_SLT;
            FN_JR:   dec = INST_JR;
            FN_SRAV: dec = INST_SRAV;
            default: dec = INST_BAD;
          endcase
        OP_ORI:   dec = INST_ORI;
        OP_LW:    dec = INST_LW;
        OP_SW:    dec = INST_SW;
        OP_BEQ:   dec = INST_BEQ;
        OP_LUI:   dec = INST_LUI;
        OP_J:     dec = INST_J;
        OP_ADDI:  dec = INST_ADDI;
        OP_ADDIU: dec = INST_ADDIU;
        OP_JAL:   dec = INST_JAL;
        OP_SB:    dec = INST_SB;
        OP_LB:    dec = INST_LB;
        OP_HLT:   dec = INST_HLT;
        default:  dec = INST_BAD;
      endcase
  end
endmodule

// File: rtl/ifu_fetch_unit.sv
// ifu_fetch_unit: PC, next-PC mux, instruction register, halt/fault flags and fetch counter
module ifu_fetch_unit
  import ifu_fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int IM_ADDR_W = 10
) (
  input logic clk,
  input logic reset,
  ifu_fetch_unit_if.slave bus
);
  logic [31:0] pc, ir, cnt, npc;
  logic halted, fault, bad_tgt;
  logic [5:0] dec;
  ifu_fetch_unit_inst_decode u_dec (.ir(ir), .dec(dec));
  // next-PC mux; a target is illegal if misaligned or outside the instruction window
  always_comb begin
    npc = bus.npc_sel == IFU_SEL_NORM ? pc + 32'd4 :
          bus.npc_sel == IFU_SEL_RELATIVE ? pc + {{14{ir[15]}}, ir[15:0], 2'b00} :
          bus.npc_sel == IFU_SEL_IRRELATIVE ? {pc[31:28], ir[25:0], 2'b00} : bus.rs_data;
    bad_tgt = npc[1:0] != 2'b00 || ((npc - PC_RESET) >> (IM_ADDR_W + 2)) != 32'd0;
  end
  // state updates gated by the old halted value, so a halt request lets its own edge's writes land
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= PC_RESET;
      ir <= 32'd0;
      cnt <= 32'd0;
      halted <= 1'b0;
      fault <= 1'b0;
    end else begin
      halted <= halted | bus.halt_sig;
      if (!halted && bus.pc_write_en && !bad_tgt) pc <= npc;
      if (!halted && bus.pc_write_en && bad_tgt) fault <= 1'b1;
      if (!halted && bus.im_next_en) begin
        ir <= bus.imem_rdata;
        cnt <= cnt + 32'd1;
      end
    end
  assign bus.imem_addr = IM_ADDR_W'((pc - PC_RESET) >> 2);
  assign bus.pc = pc;
  assign bus.instr = ir;
  assign bus.dec_inst = dec;
  assign bus.rs = ir[25:21];
  assign bus.rt = ir[20:16];
  assign bus.rd = ir[15:11];
  assign bus.imm16 = ir[15:0];
  assign bus.halted = halted;
  assign bus.pc_fault = fault;
  assign bus.fetch_count = cnt;
endmodule
